// File: rtl/mygo_chan_arb.sv
// N-to-1 round-robin write-port arbiter feeding one channel FIFO input.
// The grant is registered, held under backpressure and rotated after QUANTUM beats.
module mygo_chan_arb #(
    parameter int unsigned N_WRITERS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned QUANTUM    = 1,
    localparam int unsigned GW        = (N_WRITERS > 1) ? $clog2(N_WRITERS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_WRITERS*DATA_WIDTH-1:0] in_data,
    input  logic [N_WRITERS-1:0]            in_valid,
    output logic [N_WRITERS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy,
    output logic [31:0]                     xfer_count
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      beat_q, beat_d;
    logic [31:0]     xfer_q, xfer_d;

    logic            xfer;
    logic            release_grant;
    logic [8:0]      beat_inc;
    logic [GW:0]     idle_pick;
    logic [GW:0]     rel_pick;
    int unsigned     g;
    int unsigned     g_next;

    // Returns {found, index} of the first requester at or after start, wrapping.
    function automatic logic [GW:0] pick_first(input logic [N_WRITERS-1:0] req,
                                               input int unsigned start);
        logic          found;
        logic [GW-1:0] idx;
        int unsigned   c;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_WRITERS; k++) begin
            c = start + k;
            if (c >= N_WRITERS) begin
                c = c - N_WRITERS;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = GW'(c);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        g        = int'(grant_q);
        g_next   = (g + 1 >= N_WRITERS) ? 0 : g + 1;
        beat_inc = {1'b0, beat_q} + 9'd1;

        idle_pick = pick_first(in_valid, int'(rr_ptr_q));
        // The current owner is scanned last, so it is re-granted only when alone.
        rel_pick  = pick_first(in_valid, g_next);

        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        xfer_d   = xfer_q;

        out_valid     = 1'b0;
        out_data      = '0;
        in_ready      = '0;
        xfer          = 1'b0;
        release_grant = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (idle_pick[GW]) begin
                    state_d = StGrant;
                    grant_d = idle_pick[GW-1:0];
                    beat_d  = '0;
                end
            end
            StGrant: begin
                out_data    = in_data[g*DATA_WIDTH +: DATA_WIDTH];
                out_valid   = in_valid[g];
                in_ready[g] = out_ready;
                xfer        = out_valid && out_ready;

                if (xfer) begin
                    xfer_d = xfer_q + 32'd1;
                    beat_d = beat_inc[7:0];
                end

                release_grant = (xfer && (beat_inc == 9'(QUANTUM))) || !in_valid[g];

                if (release_grant) begin
                    rr_ptr_d = GW'(g_next);
                    beat_d   = '0;
                    if (rel_pick[GW]) begin
                        grant_d = rel_pick[GW-1:0];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            xfer_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            xfer_q   <= xfer_d;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q == StGrant);
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_mygo_chan_arb.sv
// Directed bench for mygo_chan_arb: a 2-writer/Q=1 instance and a 3-writer/Q=2 instance
// share clock and reset.
module tb_mygo_chan_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Two writers, 32-bit data, quantum 1.
    logic [31:0] d2_w0, d2_w1;
    logic [1:0]  d2_in_valid;
    logic [1:0]  d2_in_ready;
    logic [31:0] d2_out_data;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [0:0]  d2_grant;
    logic        d2_busy;
    logic [31:0] d2_xfer;

    // Three writers, 8-bit data, quantum 2.
    logic [7:0]  d3_w0, d3_w1, d3_w2;
    logic [2:0]  d3_in_valid;
    logic [2:0]  d3_in_ready;
    logic [7:0]  d3_out_data;
    logic        d3_out_valid;
    logic        d3_out_ready;
    logic [1:0]  d3_grant;
    logic        d3_busy;
    logic [31:0] d3_xfer;

    mygo_chan_arb #(.N_WRITERS(2), .DATA_WIDTH(32), .QUANTUM(1)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({d2_w1, d2_w0}),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .out_data  (d2_out_data),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .grant_id  (d2_grant),
        .busy      (d2_busy),
        .xfer_count(d2_xfer)
    );

    mygo_chan_arb #(.N_WRITERS(3), .DATA_WIDTH(8), .QUANTUM(2)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({d3_w2, d3_w1, d3_w0}),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .grant_id  (d3_grant),
        .busy      (d3_busy),
        .xfer_count(d3_xfer)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        d2_w0 = '0; d2_w1 = '0; d2_in_valid = '0; d2_out_ready = 1'b1;
        d3_w0 = '0; d3_w1 = '0; d3_w2 = '0; d3_in_valid = '0; d3_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    logic [31:0] na, nb, exp_data;
    logic [1:0]  exp_g;

    initial begin
        clear_inputs();
        #1;
        check_eq("rst_out_valid", {31'd0, d2_out_valid}, 32'd0);
        check_eq("rst_in_ready",  {30'd0, d2_in_ready}, 32'd0);
        check_eq("rst_busy",      {31'd0, d2_busy}, 32'd0);
        check_eq("rst_xfer",      d2_xfer, 32'd0);
        check_eq("rst_grant",     {31'd0, d2_grant}, 32'd0);
        check_eq("rst_out_data",  d2_out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // 1: single writer streaming 0..4
        d2_in_valid = 2'b01;
        d2_w0 = 32'd0;
        #1;
        check_eq("t1_latency", {31'd0, d2_out_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            d2_w0 = i;
            #1;
            check_eq("t1_valid", {31'd0, d2_out_valid}, 32'd1);
            check_eq("t1_data", d2_out_data, i);
            check_eq("t1_ready", {30'd0, d2_in_ready}, 32'd1);
        end
        step();
        d2_in_valid = 2'b00;
        #1;
        check_eq("t1_xfer", d2_xfer, 32'd5);
        step();
        check_eq("t1_idle_busy", {31'd0, d2_busy}, 32'd0);

        // 2: two writers contend, strict alternation
        do_reset();
        na = 0; nb = 0;
        d2_w0 = 32'hA0; d2_w1 = 32'hB0;
        d2_in_valid = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_data = (k % 2 == 0) ? 32'hA0 + na : 32'hB0 + nb;
            check_eq("t2_grant", {31'd0, d2_grant}, k % 2);
            check_eq("t2_data", d2_out_data, exp_data);
            step();
            if (k % 2 == 0) begin
                na++;
                d2_w0 = 32'hA0 + na;
            end else begin
                nb++;
                d2_w1 = 32'hB0 + nb;
            end
        end
        #1;
        check_eq("t2_xfer", d2_xfer, 32'd4);

        // 3: three writers, quantum 2
        do_reset();
        d3_w0 = 8'hC0; d3_w1 = 8'hC1; d3_w2 = 8'hC2;
        d3_in_valid = 3'b111;
        step();
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_g = 2'((k / 2) % 3);
            check_eq("t3_grant", {30'd0, d3_grant}, {30'd0, exp_g});
            check_eq("t3_data", {24'd0, d3_out_data}, 32'hC0 + exp_g);
            step();
        end
        #1;
        check_eq("t3_xfer", d3_xfer, 32'd12);

        // 4: backpressure holds the grant and the data
        do_reset();
        d2_out_ready = 1'b0;
        d2_w1 = 32'h55;
        d2_in_valid = 2'b10;
        step();
        d2_w0 = 32'h66;
        d2_in_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t4_grant", {31'd0, d2_grant}, 32'd1);
            check_eq("t4_data", d2_out_data, 32'h55);
            check_eq("t4_ready", {30'd0, d2_in_ready}, 32'd0);
            step();
        end
        d2_out_ready = 1'b1;
        #1;
        check_eq("t4_ready_open", {30'd0, d2_in_ready}, 32'd2);
        step();
        d2_in_valid = 2'b01;
        #1;
        check_eq("t4_next_grant", {31'd0, d2_grant}, 32'd0);
        check_eq("t4_next_data", d2_out_data, 32'h66);
        check_eq("t4_xfer", d2_xfer, 32'd1);

        // 5: asynchronous reset while w2 is granted and stalled
        do_reset();
        d3_w2 = 8'h77;
        d3_in_valid = 3'b100;
        step();
        step();
        d3_out_ready = 1'b0;
        #1;
        check_eq("t5_pre_grant", {30'd0, d3_grant}, 32'd2);
        check_eq("t5_pre_xfer", d3_xfer, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t5_valid", {31'd0, d3_out_valid}, 32'd0);
        check_eq("t5_ready", {29'd0, d3_in_ready}, 32'd0);
        check_eq("t5_busy", {31'd0, d3_busy}, 32'd0);
        check_eq("t5_xfer", d3_xfer, 32'd0);
        d3_in_valid = 3'b110;
        d3_w1 = 8'h11;
        @(negedge clk);
        rst = 1'b1;
        step();
        #1;
        check_eq("t5_first_grant", {30'd0, d3_grant}, 32'd1);
        check_eq("t5_first_data", {24'd0, d3_out_data}, 32'h11);

        // 6: xfer_count wrap, then granted writer drops valid
        do_reset();
        force u_dut2.xfer_q = 32'hFFFF_FFFF;
        #1;
        release u_dut2.xfer_q;
        d2_w0 = 32'h99;
        d2_in_valid = 2'b01;
        step();
        step();
        #1;
        check_eq("t6_wrap", d2_xfer, 32'd0);
        check_eq("t6_busy", {31'd0, d2_busy}, 32'd1);
        d2_out_ready = 1'b0;
        d2_in_valid = 2'b10;
        step();
        #1;
        check_eq("t6_drop_grant", {31'd0, d2_grant}, 32'd1);
        check_eq("t6_drop_xfer", d2_xfer, 32'd0);
        d2_in_valid = 2'b00;
        step();
        #1;
        check_eq("t6_idle_busy", {31'd0, d2_busy}, 32'd0);
        check_eq("t6_idle_valid", {31'd0, d2_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
